mem_port_arbiter: RTL

- Sits directly downstream of the CPU top's instruction and data SRAM-style ports.
- Merges the fetch port and the load/store port onto one shared, multi-cycle memory port using a request/acknowledge handshake.
- Serialises accesses and returns each response to the correct requester.
- This is the first step from ideal single-cycle SRAM towards a real shared memory or bus bridge.

---
 rtl/mem_port_arbiter_pkg.sv | 20 ++
 rtl/mem_port_arbiter.sv | 106 ++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: state encoding and grant constants for the fetch/load-store memory port arbiter.
// Revision 1.0
`default_nettype none

package mem_port_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BUSY_I = 3'd1,
    BUSY_D = 3'd2,
    RESP_I = 3'd3,
    RESP_D = 3'd4
  } state_t;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: merges fetch and load/store SRAM-style ports onto one multi-cycle req/ack memory port.
// Revision 1.0
`default_nettype none

module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_data_ok,
  input  logic                d_req,
  input  logic [DATA_W/8-1:0] d_wen,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_data_ok,
  output logic                m_req,
  output logic [DATA_W/8-1:0] m_wen,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  input  logic                m_ack,
  input  logic [DATA_W-1:0]   m_rdata
);

  state_t state;
  logic   last_d;
  logic   grant;

  // When both ports request, the port that did not win last time goes first.
  always_comb begin
    grant = GRANT_I;
    if (d_req && (!i_req || !last_d)) begin
      grant = GRANT_D;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last_d    <= 1'b0;
      m_req     <= 1'b0;
      m_wen     <= '0;
      m_addr    <= '0;
      m_wdata   <= '0;
      i_data_ok <= 1'b0;
      d_data_ok <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
    end else begin
      i_data_ok <= 1'b0;
      d_data_ok <= 1'b0;
      case (state)
        IDLE: begin
          if (i_req || d_req) begin
            m_req  <= 1'b1;
            last_d <= (grant == GRANT_D);
            if (grant == GRANT_D) begin
              m_wen   <= d_wen;
              m_addr  <= d_addr;
              m_wdata <= d_wdata;
              state   <= BUSY_D;
            end else begin
              m_wen   <= '0;
              m_addr  <= i_addr;
              m_wdata <= '0;
              state   <= BUSY_I;
            end
          end
        end
        BUSY_I: begin
          if (m_ack) begin
            m_req     <= 1'b0;
            i_rdata   <= m_rdata;
            i_data_ok <= 1'b1;
            state     <= RESP_I;
          end
        end
        BUSY_D: begin
          if (m_ack) begin
            m_req     <= 1'b0;
            // Stores return zero so the load/store unit never sees stale bus data.
            d_rdata   <= (m_wen == '0) ? m_rdata : '0;
            d_data_ok <= 1'b1;
            state     <= RESP_D;
          end
        end
        RESP_I, RESP_D: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          m_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
